// File: rtl/axi_slv_burst_resp_if.sv
// AXI-style burst slave bundle: AW/W/B write channels and AR/R read channels.
interface axi_slv_burst_resp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport master (
    output awid, awaddr, awlen, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
endinterface

// File: rtl/axi_slv_burst_resp.sv
// Burst response slave: sinks write bursts into a B queue, answers reads with address-pattern data.
// First R beat RESP_LAT+2 cycles after AR; awready/arready drop when the B/AR queue is full.
module axi_slv_burst_resp #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int ID_W     = 4,
  parameter int RD_DEPTH = 4,
  parameter int WR_DEPTH = 4,
  parameter int RESP_LAT = 2,
  parameter logic [ADDR_W-1:0] ERR_BASE = '0,
  parameter logic [ADDR_W-1:0] ERR_MASK = '0
) (
  input  logic                aclk,
  input  logic                aresetn,
  axi_slv_burst_resp_if.slave bus,
  output logic [15:0]         wr_done_cnt,
  output logic [15:0]         rd_done_cnt,
  output logic                proto_err
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int RP_W  = $clog2(RD_DEPTH);
  localparam int WP_W  = $clog2(WR_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_DATA  = 1'b1;
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_WAIT  = 2'd1;
  localparam logic [1:0] R_BURST = 2'd2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_ent_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [1:0]        burst;
  } ar_ent_t;

  function automatic logic resp_err(input logic [ADDR_W-1:0] addr, input logic [1:0] burst);
    return (burst == BURST_WRAP) || ((ERR_MASK != '0) && ((addr & ERR_MASK) == ERR_BASE));
  endfunction

  // Holds the ready outputs low through reset and releases them one clock later.
  logic live;
  always_ff @(posedge aclk) begin
    if (!aresetn) live <= 1'b0;
    else          live <= 1'b1;
  end

  // ---------------- write path ----------------
  logic [0:0]      w_state;
  logic [ID_W-1:0] aw_id_q;
  logic [7:0]      aw_len_q;
  logic            aw_err_q;
  logic            w_err_q;
  logic [7:0]      w_beat;
  b_ent_t          b_mem [WR_DEPTH];
  logic [WP_W:0]   b_wr;
  logic [WP_W:0]   b_rd;
  logic            b_empty, b_full, aw_hs, w_hs, w_last_beat, w_bad, b_push, b_pop;
  b_ent_t          b_head;
  logic            unused_wpayload;

  assign unused_wpayload = ^{bus.wdata, bus.wstrb};
  assign b_empty     = (b_wr == b_rd);
  assign b_full      = (b_wr[WP_W] != b_rd[WP_W]) && (b_wr[WP_W-1:0] == b_rd[WP_W-1:0]);
  assign bus.awready = live && (w_state == W_IDLE) && !b_full;
  assign bus.wready  = (w_state == W_DATA);
  assign aw_hs       = bus.awvalid && bus.awready;
  assign w_hs        = bus.wvalid && bus.wready;
  assign w_last_beat = (w_beat == aw_len_q);
  assign w_bad       = (bus.wlast != w_last_beat);
  assign b_push      = w_hs && w_last_beat;
  assign b_pop       = bus.bvalid && bus.bready;
  assign b_head      = b_empty ? '0 : b_mem[b_rd[WP_W-1:0]];
  assign bus.bvalid  = !b_empty;
  assign bus.bid     = b_head.id;
  assign bus.bresp   = b_head.resp;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state     <= W_IDLE;
      aw_id_q     <= '0;
      aw_len_q    <= '0;
      aw_err_q    <= 1'b0;
      w_err_q     <= 1'b0;
      w_beat      <= '0;
      b_wr        <= '0;
      b_rd        <= '0;
      wr_done_cnt <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_state  <= W_DATA;
        aw_id_q  <= bus.awid;
        aw_len_q <= bus.awlen;
        aw_err_q <= resp_err(bus.awaddr, bus.awburst);
        w_err_q  <= 1'b0;
        w_beat   <= '0;
      end
      // Burst length always comes from awlen; wlast only feeds the error tracking.
      if (w_hs) begin
        w_beat <= w_beat + 8'd1;
        if (w_bad) begin
          w_err_q   <= 1'b1;
          proto_err <= 1'b1;
        end
        if (w_last_beat) w_state <= W_IDLE;
      end
      if (b_push) begin
        b_mem[b_wr[WP_W-1:0]] <= '{id: aw_id_q,
                                   resp: (aw_err_q || w_err_q || w_bad) ? RESP_SLVERR : RESP_OKAY};
        b_wr <= b_wr + (WP_W+1)'(1);
      end
      if (b_pop) begin
        b_rd        <= b_rd + (WP_W+1)'(1);
        wr_done_cnt <= wr_done_cnt + 16'd1;
      end
    end
  end

  // ---------------- read path ----------------
  ar_ent_t           ar_mem [RD_DEPTH];
  logic [RP_W:0]     ar_wr, ar_rd, ar_cnt_nxt;
  ar_ent_t           ar_head;
  logic [1:0]        r_state;
  logic [3:0]        lat_cnt;
  ar_ent_t           r_cur;
  logic              r_err;
  logic [7:0]        r_beat;
  logic              ar_hs, ar_pop, r_hs, r_last;
  logic [ADDR_W-1:0] beat_addr;

  assign ar_head    = ar_mem[ar_rd[RP_W-1:0]];
  assign ar_hs      = bus.arvalid && bus.arready;
  assign ar_pop     = (r_state == R_IDLE) && (ar_wr != ar_rd);
  assign ar_cnt_nxt = ar_wr - ar_rd + (RP_W+1)'(ar_hs) - (RP_W+1)'(ar_pop);
  assign r_hs       = bus.rvalid && bus.rready;
  assign r_last     = (r_beat == r_cur.len);

  always_comb begin
    beat_addr = r_cur.addr;
    if (r_cur.burst != BURST_FIXED)
      beat_addr = (r_cur.addr + (ADDR_W'(r_beat) << OFF_W)) & ~ADDR_W'(BYTES - 1);
  end

  assign bus.rvalid = (r_state == R_BURST);
  assign bus.rid    = bus.rvalid ? r_cur.id : '0;
  assign bus.rdata  = (bus.rvalid && r_cur.burst != BURST_WRAP) ? {(DATA_W/ADDR_W){beat_addr}} : '0;
  assign bus.rresp  = (bus.rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign bus.rlast  = bus.rvalid && r_last;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ar_wr       <= '0;
      ar_rd       <= '0;
      bus.arready <= 1'b0;
      r_state     <= R_IDLE;
      lat_cnt     <= '0;
      r_cur       <= '0;
      r_err       <= 1'b0;
      r_beat      <= '0;
      rd_done_cnt <= '0;
    end else begin
      if (ar_hs) begin
        ar_mem[ar_wr[RP_W-1:0]] <= '{id: bus.arid, addr: bus.araddr, len: bus.arlen, burst: bus.arburst};
        ar_wr <= ar_wr + (RP_W+1)'(1);
      end
      // Registered from next-cycle occupancy so rready and pops never reach arready combinationally.
      bus.arready <= (ar_cnt_nxt != (RP_W+1)'(RD_DEPTH));
      case (r_state)
        R_IDLE: if (ar_pop) begin
          r_cur   <= ar_head;
          r_err   <= resp_err(ar_head.addr, ar_head.burst);
          r_beat  <= '0;
          lat_cnt <= 4'(RESP_LAT);
          ar_rd   <= ar_rd + (RP_W+1)'(1);
          r_state <= (RESP_LAT == 0) ? R_BURST : R_WAIT;
        end
        R_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) r_state <= R_BURST;
        end
        R_BURST: if (r_hs) begin
          r_beat <= r_beat + 8'd1;
          if (r_last) begin
            r_state     <= R_IDLE;
            rd_done_cnt <= rd_done_cnt + 16'd1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_slv_burst_resp.sv
// Directed + randomized bench for axi_slv_burst_resp against a burst-level reference model.
module tb_axi_slv_burst_resp;
  localparam int ADDR_W = 32, DATA_W = 64, ID_W = 4, RESP_LAT = 2;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] wr_done_cnt, rd_done_cnt;
  logic        proto_err;

  int   checks = 0, failures = 0;
  int   wr_exp = 0, rd_exp = 0;
  logic proto_exp = 1'b0;
  logic [5:0] bq [$];

  axi_slv_burst_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  axi_slv_burst_resp #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .RD_DEPTH(4), .WR_DEPTH(4),
    .RESP_LAT(RESP_LAT), .ERR_BASE(32'h0000_F000), .ERR_MASK(32'h0000_F000)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus),
    .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt), .proto_err(proto_err)
  );

  always #5 aclk = ~aclk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Error window: WRAP bursts or addresses whose bits [15:12] are all ones.
  function automatic bit win_err(input logic [31:0] a, input logic [1:0] b);
    return (b == 2'd2) || (a[15:12] == 4'hF);
  endfunction

  function automatic logic [70:0] exp_r(input logic [3:0] id, input logic [31:0] a,
                                        input logic [7:0] len, input logic [1:0] b, input int i);
    logic [31:0] ba;
    logic [63:0] d;
    ba = (b == 2'd0) ? a : ((a + 32'(i) * 32'd8) & ~32'd7);
    d  = (b == 2'd2) ? 64'd0 : {ba, ba};
    return {id, d, (win_err(a, b) ? 2'd2 : 2'd0), (i == int'(len))};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] b);
    int n = 0;
    bus.arid = id; bus.araddr = a; bus.arlen = len; bus.arburst = b; bus.arvalid = 1'b1;
    while (!bus.arready && n < 200) begin @(negedge aclk); n++; end
    check("arready_wait", bus.arready, 1'b1);
    @(negedge aclk);
    bus.arvalid = 1'b0;
  endtask

  task automatic collect_r(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] b, input bit rnd, input bit chk_lat);
    int beat = 0, n = 0, lat = 1;
    bit seen = 0;
    while (beat <= int'(len) && n < 3000) begin
      bus.rready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bus.rvalid) begin
        if (!seen && chk_lat) check("r_first_latency", lat, RESP_LAT + 2);
        seen = 1;
        check("r_beat", {bus.rid, bus.rdata, bus.rresp, bus.rlast}, exp_r(id, a, len, b, beat));
        if (bus.rready) beat++;
      end
      @(negedge aclk); n++; lat++;
    end
    bus.rready = 1'b0;
    check("r_all_beats", beat, int'(len) + 1);
    rd_exp++;
    check("rd_done_cnt", rd_done_cnt, rd_exp[15:0]);
  endtask

  // mode 0: proper wlast; 1: wlast only on beat 'bad' (< len); 2: wlast never set
  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] b, input int mode, input int bad);
    int n = 0;
    bus.awid = id; bus.awaddr = a; bus.awlen = len; bus.awburst = b; bus.awvalid = 1'b1;
    while (!bus.awready && n < 200) begin @(negedge aclk); n++; end
    check("awready_wait", bus.awready, 1'b1);
    @(negedge aclk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata  = {$urandom, $urandom};
      bus.wstrb  = 8'($urandom);
      bus.wlast  = (mode == 1) ? (i == bad) : (mode == 2) ? 1'b0 : (i == int'(len));
      bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 200) begin @(negedge aclk); n++; end
      check("wready_wait", bus.wready, 1'b1);
      @(negedge aclk);
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      if (i < int'(len) && $urandom_range(0, 3) == 0) @(negedge aclk);
    end
    bq.push_back({id, ((win_err(a, b) || mode != 0) ? 2'd2 : 2'd0)});
    if (mode != 0) proto_exp = 1'b1;
    if (bq.size() == 1) check("bvalid_next_clk", bus.bvalid, 1'b1);
    check("proto_err", proto_err, proto_exp);
  endtask

  task automatic take_b();
    int n = 0;
    logic [5:0] e;
    while (!bus.bvalid && n < 200) begin @(negedge aclk); n++; end
    check("bvalid_wait", bus.bvalid, 1'b1);
    e = bq.pop_front();
    check("b_id_resp", {bus.bid, bus.bresp}, e);
    repeat ($urandom_range(0, 2)) begin
      @(negedge aclk);
      check("b_hold", {bus.bvalid, bus.bid, bus.bresp}, {1'b1, e});
    end
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
    wr_exp++;
    check("wr_done_cnt", wr_done_cnt, wr_exp[15:0]);
  endtask

  logic [31:0] ba [5];
  logic [7:0]  bl [5];
  logic [1:0]  bb [5];
  int          n, stray;

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset state
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
    check("rst_valid", {bus.bvalid, bus.rvalid}, 2'b00);
    check("rst_b", {bus.bid, bus.bresp}, 6'd0);
    check("rst_r", {bus.rid, bus.rdata, bus.rresp, bus.rlast}, 71'd0);
    check("rst_cnt", {wr_done_cnt, rd_done_cnt, proto_err}, 33'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("ready_after_rst", {bus.awready, bus.arready}, 2'b11);

    // INCR read, 4 beats from 0x1000
    issue_ar(4'h3, 32'h0000_1000, 8'd3, 2'd1);
    collect_r(4'h3, 32'h0000_1000, 8'd3, 2'd1, 1'b0, 1'b1);

    // Error window vs. normal write, then bad wlast
    do_write(4'h5, 32'h0000_F004, 8'd1, 2'd1, 0, 0); take_b();
    do_write(4'h6, 32'h0000_0004, 8'd1, 2'd1, 0, 0); take_b();
    do_write(4'h7, 32'h0000_2000, 8'd2, 2'd1, 1, 0); take_b();

    // Fill the B queue, then drain it in order
    for (int k = 0; k < 4; k++)
      do_write(4'(k + 8), $urandom, 8'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 0, 0);
    check("awready_b_full", bus.awready, 1'b0);
    for (int k = 0; k < 4; k++) take_b();
    check("awready_b_drained", bus.awready, 1'b1);

    // 256-beat bursts with address wrap-around
    issue_ar(4'h1, 32'hFFFF_FF84, 8'd255, 2'd1);
    collect_r(4'h1, 32'hFFFF_FF84, 8'd255, 2'd1, 1'b0, 1'b1);
    do_write(4'h2, 32'h0000_0010, 8'd255, 2'd1, 0, 0); take_b();

    // AR backpressure with rready held low
    for (int k = 0; k < 5; k++) begin
      ba[k] = $urandom; bl[k] = 8'($urandom_range(0, 3)); bb[k] = 2'(k % 3);
      issue_ar(4'(k), ba[k], bl[k], bb[k]);
    end
    check("arready_q_full", bus.arready, 1'b0);
    repeat (4) begin
      check("r_stall", {bus.rvalid, bus.rid, bus.rdata, bus.rresp, bus.rlast},
            {1'b1, exp_r(4'd0, ba[0], bl[0], bb[0], 0)});
      @(negedge aclk);
    end
    for (int k = 0; k < 5; k++) collect_r(4'(k), ba[k], bl[k], bb[k], 1'b1, 1'b0);
    check("arready_q_drained", bus.arready, 1'b1);

    // Randomized mix of reads and writes
    for (int it = 0; it < 40; it++) begin
      logic [31:0] a;
      logic [7:0]  len;
      logic [1:0]  bst;
      int          mode, bad;
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[15:12] = 4'hF;
      len = 8'($urandom_range(0, 12));
      bst = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        issue_ar(4'(it), a, len, bst);
        collect_r(4'(it), a, len, bst, 1'b1, 1'b1);
      end else begin
        bad = 0;
        if (len == 0) mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
        else begin
          mode = $urandom_range(0, 2);
          bad  = $urandom_range(0, int'(len) - 1);
        end
        do_write(4'(it), a, len, bst, mode, bad);
        take_b();
      end
    end

    // Reset while beat 2 of an 8-beat read is on the bus
    issue_ar(4'h9, 32'h0000_4000, 8'd7, 2'd1);
    bus.rready = 1'b1;
    n = 0;
    while (!bus.rvalid && n < 100) begin @(negedge aclk); n++; end
    check("rvalid_before_rst", bus.rvalid, 1'b1);
    @(negedge aclk);
    @(negedge aclk);
    check("r_beat2", {bus.rid, bus.rdata, bus.rresp, bus.rlast}, exp_r(4'h9, 32'h0000_4000, 8'd7, 2'd1, 2));
    aresetn = 1'b0;
    @(negedge aclk);
    check("rst_mid_rvalid", bus.rvalid, 1'b0);
    check("rst_mid_cnt", {wr_done_cnt, rd_done_cnt, proto_err}, 33'd0);
    aresetn = 1'b1;
    stray = 0;
    repeat (20) begin
      @(negedge aclk);
      if (bus.rvalid || bus.bvalid) stray++;
    end
    check("no_stray_resp", stray, 0);
    check("ready_after_mid_rst", {bus.awready, bus.arready}, 2'b11);
    bus.rready = 1'b0;
    rd_exp = 0; wr_exp = 0; proto_exp = 1'b0; bq.delete();
    issue_ar(4'hA, 32'h0000_0100, 8'd2, 2'd1);
    collect_r(4'hA, 32'h0000_0100, 8'd2, 2'd1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_slv_burst_resp.md
AXI_SLV_BURST_RESP -- requirements
Module: axi_slv_burst_resp

Interface
REQ-001 Parameter ADDR_W, default 32, address width of AW/AR channels.
REQ-002 Parameter DATA_W, default 64, data width; legal values 32, 64, 128; must be a multiple of ADDR_W.
REQ-003 Parameter ID_W, default 4, transaction ID width.
REQ-004 Parameter RD_DEPTH, default 4, AR queue entries (power of 2, at least 2).
REQ-005 Parameter WR_DEPTH, default 4, B queue entries (power of 2, at least 2).
REQ-006 Parameter RESP_LAT, default 2, range 0-15, idle cycles inserted before the first R beat of each burst.
REQ-007 Parameters ERR_BASE and ERR_MASK, default 0 and 0 (ADDR_W each), define the error window.
REQ-008 aclk  in  1  single clock; all logic is on the rising edge.
REQ-009 aresetn  in  1  reset, synchronous and active-low.
REQ-010 AW  in/out  awid ID_W, awaddr ADDR_W, awlen 8, awburst 2, awvalid 1 (in); awready 1 (out).
REQ-011 W  in/out  wdata DATA_W, wstrb DATA_W/8, wlast 1, wvalid 1 (in); wready 1 (out).
REQ-012 B  out/in  bid ID_W, bresp 2, bvalid 1 (out); bready 1 (in).
REQ-013 AR  in/out  arid ID_W, araddr ADDR_W, arlen 8, arburst 2, arvalid 1 (in); arready 1 (out).
REQ-014 R  out/in  rid ID_W, rdata DATA_W, rresp 2, rlast 1, rvalid 1 (out); rready 1 (in).
REQ-015 wr_done_cnt  out  16  count of completed B handshakes, wraps modulo 2^16.
REQ-016 rd_done_cnt  out  16  count of completed R handshakes with rlast set, wraps modulo 2^16.
REQ-017 proto_err  out  1  sticky flag; set on a wlast protocol violation.

Function
REQ-018 Write FSM states are W_IDLE and W_DATA. awready is 1 only in W_IDLE when the B queue is not full; an AW handshake moves the FSM to W_DATA.
REQ-019 In W_DATA, wready is 1; each W handshake increments the beat counter. The beat with index awlen ends the burst and returns the FSM to W_IDLE.
REQ-020 wlast mismatch: if wlast is 1 on a beat other than the last, or 0 on the last beat, the burst ends on beat awlen, bresp=SLVERR(2), and proto_err sets.
REQ-021 Write response: on the final W beat, {awid, resp} is pushed to the B queue.
  - resp = SLVERR if awburst=WRAP(2) or (awaddr & ERR_MASK) == ERR_BASE with ERR_MASK nonzero; otherwise OKAY(0).
  - wdata and wstrb are discarded.
REQ-022 bvalid=1 whenever the B queue is non-empty; bid/bresp come from the head entry. The head is popped on bvalid&bready and wr_done_cnt increments.
REQ-023 A push into an empty B queue makes bvalid 1 on the next clock.
REQ-024 arready = AR queue not full, registered; no combinational path from rready or any pop. An AR handshake pushes {arid, araddr, arlen, arburst}.
REQ-025 Read FSM states are R_IDLE, R_WAIT and R_BURST.
  - R_IDLE with the queue non-empty: pop the head, load the latency counter with RESP_LAT, go to R_WAIT (or directly to R_BURST if RESP_LAT=0).
  - R_WAIT: decrement the counter each clock; go to R_BURST when it reaches 0.
REQ-026 In R_BURST, rvalid=1.
  - Beat address: INCR(1) = base + beat*(DATA_W/8), low log2(DATA_W/8) bits cleared; FIXED(0) = base.
  - rdata = beat address replicated DATA_W/ADDR_W times.
  - rid = arid; rlast=1 on beat arlen.
REQ-027 rresp uses the same rule as REQ-021, evaluated on the start address; WRAP bursts return SLVERR with rdata zero.
REQ-028 With rvalid=1 and rready=0, rid, rdata, rresp and rlast stay stable.
REQ-029 An R handshake with rlast set returns the FSM to R_IDLE and increments rd_done_cnt.
REQ-030 Latency: AR handshake into an idle engine with an empty queue gives first rvalid exactly RESP_LAT+2 clocks later; back-to-back bursts add RESP_LAT+1 clocks between the last and first beats.
REQ-031 A simultaneous push and pop on a full queue is permitted; the ready signal remains 0 for that cycle.
REQ-032 The 8-bit awlen/arlen supports 256-beat bursts; INCR address arithmetic wraps modulo 2^ADDR_W without error.

Reset
REQ-033 While aresetn=0 at a clock edge:
  - both FSMs go to IDLE and both queues empty;
  - awready, wready, arready, bvalid and rvalid are 0;
  - bid, bresp, rid, rdata, rresp, rlast, wr_done_cnt, rd_done_cnt and proto_err are 0.
REQ-034 Reset mid-burst discards all partial bursts and queued responses; no response is emitted for them after release.
REQ-035 awready and arready go to 1 on the first clock after aresetn returns to 1.

Verification
REQ-036 INCR read: araddr=0x1000, arlen=3, DATA_W=64, RESP_LAT=2, rready=1 -> first rvalid 4 clocks after the handshake; rdata beats {0x1000,0x1000}, {0x1008,0x1008}, {0x1010,0x1010}, {0x1018,0x1018}; rlast on beat 3; rd_done_cnt=1.
REQ-037 Write: awlen=1, two W beats with wlast on beat 1, ERR_MASK=0xF000, ERR_BASE=0xF000, awaddr=0xF004 -> bresp=2, bid=awid; with awaddr=0x0004 -> bresp=0; proto_err stays 0.
REQ-038 Bad wlast: awlen=2 with wlast on beat 0 -> all 3 beats accepted, bresp=2, proto_err=1 until reset.
REQ-039 Backpressure: 5 ARs with rready=0 and RD_DEPTH=4 -> arready falls after the 4th accept plus the one engine pop; R outputs stay stable; releasing rready returns all bursts in order.
REQ-040 Reset during beat 2 of an arlen=7 read -> rvalid=0 next clock, counters 0, no further R beats; a new AR completes normally.
